// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one operand pair per start, product after WIDTH RUN cycles.
// Optional two's-complement mode when SIGNED_MULT_EN is defined.
module seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   mcand, mcand_nx;
  logic [PW-1:0]   acc, acc_nx;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   product_nx;
  logic [WIDTH-1:0] mplier, mplier_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            busy_nx, done_nx;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      mcand   <= mcand_nx;
      acc     <= acc_nx;
      mplier  <= mplier_nx;
      cnt     <= cnt_nx;
      product <= product_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

  // Next-state, datapath step and registered-output next values
  always_comb begin
    state_nx   = state;
    mcand_nx   = mcand;
    acc_nx     = acc;
    mplier_nx  = mplier;
    cnt_nx     = cnt;
    product_nx = product;
    busy_nx    = 1'b0;
    done_nx    = 1'b0;
    addend     = mplier[0] ? mcand : '0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
`ifdef SIGNED_MULT_EN
          mcand_nx = {{WIDTH{a[WIDTH-1]}}, a};
`else
          mcand_nx = PW'(a);
`endif
          mplier_nx = b;
          acc_nx    = '0;
          cnt_nx    = CW'(WIDTH);
          state_nx  = RUN;
          busy_nx   = 1'b1;
        end
      end
      RUN: begin
`ifdef SIGNED_MULT_EN
        // The last multiplier bit carries negative weight in two's complement
        if (cnt == CW'(1)) acc_nx = acc - addend;
        else               acc_nx = acc + addend;
`else
        acc_nx = acc + addend;
`endif
        mcand_nx  = mcand << 1;
        mplier_nx = mplier >> 1;
        cnt_nx    = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nx   = DONE;
          done_nx    = 1'b1;
          product_nx = acc_nx;
        end else begin
          busy_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier for the vital-sign processing datapath. It replaces the fixed 2-bit combinational multiplier wherever operands are wider, for example in sensor scaling and threshold products. It accepts one operand pair per start pulse, computes the product over WIDTH clock cycles, then signals completion with a one-cycle done pulse. The product is held stable until the next accepted start.

## Interface
- WIDTH, 8: operand width in bits; legal range 2..32.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request; sampled on the rising edge of clk.
- a  input  WIDTH  multiplicand; captured when start is accepted.
- b  input  WIDTH  multiplier; captured when start is accepted.
- busy  output  1  high while a multiplication is in progress.
- done  output  1  single-cycle pulse; product is valid.
- product  output  2*WIDTH  result; registered and held until the next accepted start.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → capture a into the multiplicand register and b into the multiplier shift register.
  - Clear the accumulator, load the bit counter with WIDTH, go to RUN.
- RUN, each cycle:
  - If the LSB of the multiplier register is 1, add the multiplicand, aligned to the current bit position, into the 2*WIDTH accumulator.
  - Shift the multiplier register right by 1; decrement the counter.
  - When the counter reaches 1 on this edge, go to DONE.
- Arithmetic:
  - The accumulator is 2*WIDTH bits wide and never overflows for unsigned operands.
  - The maximum result is (2^WIDTH−1)^2.
- DONE:
  - product is loaded from the accumulator; done=1 for exactly one cycle.
  - Next state is IDLE, or RUN if start=1 in this cycle (back-to-back operation; new operands are captured).
- start is ignored while in RUN. It is not queued and does not corrupt the operation in progress.
- a and b are don't-care except on the accepting edge.
- Reset, asserted at any time including mid-RUN:
  - Go to IDLE immediately.
  - busy=0, done=0, product=0, accumulator and counter cleared.
  - The aborted operation never produces done.

## Timing
- Reset values: busy=0, done=0, product=0, state IDLE.
- Accepting edge E0 (start=1 in IDLE or DONE):
  - busy=1 from E0 through edge E_WIDTH.
  - At edge E_WIDTH: busy=0, done=1, product valid.
- Latency: WIDTH+1 rising edges from the accepting edge to done high. For WIDTH=8, done is seen in cycle 9 after start.
- done falls at the following edge. product holds its value through IDLE until the DONE of the next operation.
- Throughput, back-to-back: one result every WIDTH+1 cycles. In the DONE cycle, busy=0 and start is accepted.
- busy and done are never high simultaneously.

## Configuration
- SIGNED_MULT_EN defined:
  - a, b and product are two's complement.
  - The multiplicand is sign-extended to 2*WIDTH bits.
  - In the final RUN cycle (the sign bit of b), the aligned multiplicand is subtracted instead of added.
  - Latency is unchanged.
- SIGNED_MULT_EN undefined: unsigned operation only. No sign-handling logic is present.

## Test plan
- WIDTH=8, reset released, a=3, b=5, start for 1 cycle → busy for 8 cycles, done in cycle 9, product=15, held afterwards.
- a=255, b=255 → product=65025 (0xFE01); a=0, b=200 → product=0, with the same latency.
- Back-to-back: start held high across DONE with a=12, b=11 → second done exactly 9 cycles after the first, product=132.
- start re-pulsed mid-RUN with different operands → ignored; original product delivered on schedule.
- rst_n pulsed low at cycle 4 of RUN → busy=0, product=0 immediately; no done pulse; the next start completes normally.
- SIGNED_MULT_EN, a=8'hFD (−3), b=5 → product=16'hFFF1 (−15); a=−128, b=−128 → product=16384.
